// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - shares one single-port BRAM between instruction-fetch and load/store ports
// Round-robin on ties; one BRAM enable per access; done pulse RD_LAT+1 cycles after grant.
module bram_port_arbiter #(
    parameter int AW     = 12,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            ins_req_i,
    input  logic [AW-1:0]   ins_addr_i,
    output logic            ins_grant_o,
    output logic            ins_done_o,
    output logic [DW-1:0]   ins_rdata_o,

    input  logic            dat_req_i,
    input  logic            dat_we_i,
    input  logic [AW-1:0]   dat_addr_i,
    input  logic [DW-1:0]   dat_wdata_i,
    input  logic [DW/8-1:0] dat_wstrb_i,
    output logic            dat_grant_o,
    output logic            dat_done_o,
    output logic [DW-1:0]   dat_rdata_o,

    output logic            bram_en_o,
    output logic [DW/8-1:0] bram_we_o,
    output logic [AW-1:0]   bram_addr_o,
    output logic [DW-1:0]   bram_wdata_o,
    input  logic [DW-1:0]   bram_rdata_i,

    output logic            busy_o
);

    localparam int SW = DW / 8;
    localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      cnt_q;

    logic            last_dat_q;
    logic            owner_dat_q;
    logic            is_read_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [SW-1:0]   we_q;

    logic            ins_done_q;
    logic            dat_done_q;
    logic [DW-1:0]   ins_rdata_q;
    logic [DW-1:0]   dat_rdata_q;

    logic            any_req;
    logic            pick_dat;
    logic            wait_last;
    logic            select;

    // Ties go to whichever port did not win the previous selection.
    assign any_req   = ins_req_i | dat_req_i;
    assign pick_dat  = dat_req_i & (~ins_req_i | ~last_dat_q);
    assign wait_last = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign select    = any_req && ((state_q == ST_IDLE) || wait_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = any_req ? ST_ISSUE : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bram_en_o   = 1'b0;
        bram_we_o   = '0;
        ins_grant_o = 1'b0;
        dat_grant_o = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                bram_en_o   = 1'b1;
                bram_we_o   = we_q;
                ins_grant_o = ~owner_dat_q;
                dat_grant_o = owner_dat_q;
                busy_o      = 1'b1;
            end
            ST_WAIT: begin
                busy_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else if (state_q == ST_ISSUE) begin
            cnt_q <= CNT_INIT;
        end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Request fields are captured at the selection edge so the requester may move on after grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_dat_q  <= 1'b1;
            owner_dat_q <= 1'b0;
            is_read_q   <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= '0;
        end else if (select) begin
            last_dat_q  <= pick_dat;
            owner_dat_q <= pick_dat;
            is_read_q   <= ~(pick_dat & dat_we_i);
            addr_q      <= pick_dat ? dat_addr_i : ins_addr_i;
            we_q        <= (pick_dat && dat_we_i) ? dat_wstrb_i : '0;
            if (pick_dat) begin
                wdata_q <= dat_wdata_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ins_done_q  <= 1'b0;
            dat_done_q  <= 1'b0;
            ins_rdata_q <= '0;
            dat_rdata_q <= '0;
        end else begin
            ins_done_q <= wait_last & ~owner_dat_q;
            dat_done_q <= wait_last & owner_dat_q;
            if (wait_last && is_read_q) begin
                if (owner_dat_q) begin
                    dat_rdata_q <= bram_rdata_i;
                end else begin
                    ins_rdata_q <= bram_rdata_i;
                end
            end
        end
    end

    assign ins_done_o   = ins_done_q;
    assign dat_done_o   = dat_done_q;
    assign ins_rdata_o  = ins_rdata_q;
    assign dat_rdata_o  = dat_rdata_q;
    assign bram_addr_o  = addr_q;
    assign bram_wdata_o = wdata_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - randomized scoreboard bench for bram_port_arbiter at RD_LAT 1 and 3
module tb_bram_port_arbiter;

    typedef struct {
        logic [11:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    typedef struct {
        int          cyc;
        bit          dat;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    int n_vec = 0;
    int n_err = 0;
    bit fin [2];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int lat, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL lat%0d %s: got %0h expected %0h", lat, name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        if (i == 16) return 32'hA5A5_0010;
        if (i == 32) return 32'h0;
        return 32'(i) * 32'h9E37_79B9 + 32'h0123_4567;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lat
        localparam int RD = (g == 0) ? 1 : 3;

        logic        rst_n;
        logic        ins_req, ins_grant, ins_done;
        logic [11:0] ins_addr;
        logic [31:0] ins_rdata;
        logic        dat_req, dat_we, dat_grant, dat_done;
        logic [11:0] dat_addr;
        logic [31:0] dat_wdata, dat_rdata;
        logic [3:0]  dat_wstrb;
        logic        bram_en, busy;
        logic [3:0]  bram_we;
        logic [11:0] bram_addr;
        logic [31:0] bram_wdata, bram_rdata;

        bram_port_arbiter #(.AW(12), .DW(32), .RD_LAT(RD)) u_dut (
            .clk(clk), .reset(rst_n),
            .ins_req_i(ins_req), .ins_addr_i(ins_addr), .ins_grant_o(ins_grant),
            .ins_done_o(ins_done), .ins_rdata_o(ins_rdata),
            .dat_req_i(dat_req), .dat_we_i(dat_we), .dat_addr_i(dat_addr),
            .dat_wdata_i(dat_wdata), .dat_wstrb_i(dat_wstrb), .dat_grant_o(dat_grant),
            .dat_done_o(dat_done), .dat_rdata_o(dat_rdata),
            .bram_en_o(bram_en), .bram_we_o(bram_we), .bram_addr_o(bram_addr),
            .bram_wdata_o(bram_wdata), .bram_rdata_i(bram_rdata), .busy_o(busy)
        );

        // BRAM model: data for an access is visible RD cycles after its enable edge, garbage otherwise.
        logic [31:0] mem [64];
        logic [31:0] pipe [RD];
        bit          seeded = 1'b0;
        assign bram_rdata = pipe[RD-1];

        always @(posedge clk) begin
            if (!seeded) begin
                for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
                seeded <= 1'b1;
            end else if (bram_en && bram_we != 4'b0) begin
                for (int b = 0; b < 4; b++)
                    if (bram_we[b]) mem[bram_addr[5:0]][8*b +: 8] <= bram_wdata[8*b +: 8];
            end
            pipe[0] <= (bram_en && bram_we == 4'b0) ? mem[bram_addr[5:0]] : $urandom();
            for (int i = 1; i < RD; i++) pipe[i] <= pipe[i-1];
        end

        logic [31:0] ref_mem [64];
        txn_t        ins_q[$];
        txn_t        dat_q[$];
        exp_t        sb[$];
        int          cyc = 0;
        int          next_sel, grant_cyc, acc_start;
        bit          lw_dat, have_acc, cur_dat;
        txn_t        cur;
        logic [11:0] last_addr;
        logic [31:0] last_ins, last_dat;

        initial forever begin
            @(posedge clk);
            cyc++;
        end

        task automatic model_reset();
            next_sel  = 0;
            grant_cyc = -1;
            acc_start = 0;
            have_acc  = 1'b0;
            lw_dat    = 1'b1;
            last_addr = '0;
            last_ins  = '0;
            last_dat  = '0;
            sb.delete();
        endtask

        // Monitor / reference model: serialized accesses, selection allowed from next_sel on.
        initial begin
            bit         due, due_dat, gnt, rd;
            exp_t       e;
            logic [3:0] ewe;
            model_reset();
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    model_reset();
                    chk(RD, "rst_outs", 64'({bram_en, bram_we, ins_grant, dat_grant, ins_done, dat_done, busy}), 64'(0));
                    chk(RD, "rst_rdata", 64'({ins_rdata, dat_rdata}), 64'(0));
                end else begin
                    due = 1'b0;
                    due_dat = 1'b0;
                    if (sb.size() > 0 && sb[0].cyc == cyc) begin
                        e = sb.pop_front();
                        due = 1'b1;
                        due_dat = e.dat;
                        if (e.rd) begin
                            if (e.dat) last_dat = e.data;
                            else last_ins = e.data;
                        end
                    end
                    chk(RD, "ins_done", 64'(ins_done), 64'(due && !due_dat));
                    chk(RD, "dat_done", 64'(dat_done), 64'(due && due_dat));
                    chk(RD, "ins_rdata", 64'(ins_rdata), 64'(last_ins));
                    chk(RD, "dat_rdata", 64'(dat_rdata), 64'(last_dat));

                    gnt = (grant_cyc == cyc);
                    if (gnt) last_addr = cur.addr;
                    ewe = (gnt && cur_dat && cur.we) ? cur.wstrb : 4'b0;
                    chk(RD, "ins_grant", 64'(ins_grant), 64'(gnt && !cur_dat));
                    chk(RD, "dat_grant", 64'(dat_grant), 64'(gnt && cur_dat));
                    chk(RD, "bram_en", 64'(bram_en), 64'(gnt));
                    chk(RD, "bram_we", 64'(bram_we), 64'(ewe));
                    chk(RD, "bram_addr", 64'(bram_addr), 64'(last_addr));
                    if (gnt && cur_dat && cur.we) chk(RD, "bram_wdata", 64'(bram_wdata), 64'(cur.wdata));
                    chk(RD, "busy", 64'(busy), 64'(have_acc && cyc >= acc_start && cyc <= acc_start + RD));

                    if (cyc >= next_sel && (ins_req || dat_req)) begin
                        cur_dat = dat_req && (!ins_req || !lw_dat);
                        lw_dat = cur_dat;
                        if (cur_dat) begin
                            cur.addr = dat_addr; cur.we = dat_we; cur.wdata = dat_wdata; cur.wstrb = dat_wstrb;
                        end else begin
                            cur.addr = ins_addr; cur.we = 1'b0; cur.wdata = '0; cur.wstrb = '0;
                        end
                        grant_cyc = cyc + 1;
                        acc_start = cyc + 1;
                        have_acc = 1'b1;
                        next_sel = cyc + 1 + RD;
                        rd = !(cur_dat && cur.we);
                        if (!rd)
                            for (int b = 0; b < 4; b++)
                                if (cur.wstrb[b]) ref_mem[cur.addr[5:0]][8*b +: 8] = cur.wdata[8*b +: 8];
                        e.cyc = cyc + 2 + RD;
                        e.dat = cur_dat;
                        e.rd = rd;
                        e.data = ref_mem[cur.addr[5:0]];
                        sb.push_back(e);
                    end
                end
            end
        end

        // Requester: hold each request until its grant, then present the next queued one.
        initial begin
            bit gi, gd;
            ins_req = 1'b0; ins_addr = '0;
            dat_req = 1'b0; dat_we = 1'b0; dat_addr = '0; dat_wdata = '0; dat_wstrb = '0;
            forever begin
                @(negedge clk);
                gi = ins_grant;
                gd = dat_grant;
                @(posedge clk);
                #1;
                if (!rst_n) begin
                    ins_req = 1'b0;
                    dat_req = 1'b0;
                end else begin
                    if (gi && ins_q.size() > 0) ins_q.delete(0);
                    if (gd && dat_q.size() > 0) dat_q.delete(0);
                    if (ins_q.size() > 0) begin
                        ins_req = 1'b1; ins_addr = ins_q[0].addr;
                    end else ins_req = 1'b0;
                    if (dat_q.size() > 0) begin
                        dat_req = 1'b1; dat_we = dat_q[0].we; dat_addr = dat_q[0].addr;
                        dat_wdata = dat_q[0].wdata; dat_wstrb = dat_q[0].wstrb;
                    end else dat_req = 1'b0;
                end
            end
        end

        task automatic push_ins(input logic [11:0] a);
            txn_t t;
            t.addr = a; t.we = 1'b0; t.wdata = '0; t.wstrb = '0;
            ins_q.push_back(t);
        endtask

        task automatic push_dat(input logic we, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
            txn_t t;
            t.addr = a; t.we = we; t.wdata = d; t.wstrb = s;
            dat_q.push_back(t);
        endtask

        task automatic drain();
            bit ok = 1'b0;
            for (int t = 0; t < 2000 && !ok; t++) begin
                @(negedge clk);
                #1;
                ok = (ins_q.size() == 0 && dat_q.size() == 0 && !ins_req && !dat_req && sb.size() == 0);
            end
            chk(RD, "drain", 64'(ok), 64'(1));
        endtask

        task automatic pulse_reset();
            @(posedge clk);
            #2 rst_n = 1'b0;
            ins_q.delete();
            dat_q.delete();
            #1;
            chk(RD, "async_rst_outs", 64'({bram_en, ins_grant, dat_grant, ins_done, dat_done, busy}), 64'(0));
            chk(RD, "async_rst_rdata", 64'({ins_rdata, dat_rdata}), 64'(0));
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
        endtask

        initial begin
            bit seen;
            rst_n = 1'b0;
            for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;

            push_ins(12'h010);
            drain();
            chk(RD, "t1_ins_rdata", 64'(ins_rdata), 64'(32'hA5A5_0010));

            pulse_reset();
            push_ins(12'h011);
            push_dat(1'b0, 12'h012, '0, '0);
            drain();

            for (int i = 0; i < 4; i++) begin
                push_ins(12'h030 + 12'(i));
                push_dat(1'b0, 12'h038 + 12'(i), '0, '0);
            end
            drain();

            push_dat(1'b1, 12'h020, 32'hDEAD_BEEF, 4'b0011);
            push_dat(1'b0, 12'h020, '0, '0);
            drain();
            chk(RD, "t4_dat_rdata", 64'(dat_rdata), 64'(32'h0000_BEEF));

            for (int i = 0; i < 60; i++) begin
                case ($urandom_range(0, 2))
                    0: push_ins(12'($urandom_range(0, 63)));
                    1: push_dat(1'b0, 12'($urandom_range(0, 63)), '0, '0);
                    default: push_dat(1'b1, 12'($urandom_range(0, 63)), $urandom(), 4'($urandom_range(1, 15)));
                endcase
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            drain();

            // Reset in the middle of an instruction read: the access is dropped without a done pulse.
            push_ins(12'h015);
            seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
                @(negedge clk);
                seen = ins_grant;
            end
            chk(RD, "t6_grant_seen", 64'(seen), 64'(1));
            pulse_reset();
            push_ins(12'h016);
            push_dat(1'b0, 12'h017, '0, '0);
            drain();

            fin[g] = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 60000 && !(fin[0] && fin[1]); t++) @(posedge clk);
        chk(0, "all_finished", 64'(fin[0] && fin[1]), 64'(1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
